// File: rtl/pc_unit.sv
// Program counter and next-PC sequencer for the single-cycle RISC-V core.
// Handles the applied branch decision, stall, halt/resume, the sticky misaligned-target trap and a taken-branch count.
module pc_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pc_src,
    input  logic signed [XLEN-1:0]  imm,
    input  logic                    stall,
    input  logic                    halt_req,
    input  logic                    resume,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         pc_plus4,
    output logic [XLEN-1:0]         branch_target,
    output logic                    halted,
    output logic                    trap,
    output logic [CNT_W-1:0]        taken_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [XLEN-1:0]    pc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               misaligned;

    // The counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Both adders wrap modulo 2^XLEN; imm is two's complement, so a negative offset branches backward.
    assign pc_plus4      = pc + XLEN'(4);
    assign branch_target = pc + $unsigned(imm);
    assign misaligned    = |branch_target[1:0];

    assign halted = (state == HALT);
    assign trap   = (state == TRAP);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = taken_count;
        unique case (state)
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (!stall) begin
                    if (pc_src) begin
                        if (misaligned) begin
                            // pc keeps the address of the faulting branch.
                            state_nxt = TRAP;
                        end else begin
                            pc_nxt  = branch_target;
                            cnt_nxt = sat_inc(taken_count);
                        end
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            HALT: begin
                // Resume only re-enters RUN; the first advance happens on the next edge.
                if (resume) begin
                    state_nxt = RUN;
                end
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            taken_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            taken_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the expected architectural state is pushed when each cycle's inputs are driven
// and popped for comparison after the clock edge.
module tb_pc_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam logic [XLEN-1:0] RST_PC = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   reset, pc_src, stall, halt_req, resume;
    logic signed [XLEN-1:0] imm;
    logic [XLEN-1:0]        pc, pc_plus4, branch_target;
    logic                   halted, trap;
    logic [CNT_W-1:0]       taken_count;

    pc_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .imm(imm), .stall(stall),
        .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .halted(halted), .trap(trap),
        .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic             halted;
        logic             trap;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct packed {
        logic            r, ps, st, hr, rs;
        logic [XLEN-1:0] im;
    } stim_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 = run, 1 = halt, 2 = trap.
    logic [XLEN-1:0]  m_pc;
    int               m_st;
    logic [CNT_W-1:0] m_cnt;

    function automatic stim_t mk(logic r, logic ps, logic st, logic hr, logic rs, logic [XLEN-1:0] im);
        stim_t s;
        s.r = r; s.ps = ps; s.st = st; s.hr = hr; s.rs = rs; s.im = im;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc = pc; o.halted = halted; o.trap = trap; o.cnt = taken_count;
        return o;
    endfunction

    task automatic step(input stim_t s);
        logic [XLEN-1:0] tgt;
        obs_t e;
        reset = s.r; pc_src = s.ps; stall = s.st; halt_req = s.hr; resume = s.rs; imm = s.im;
        tgt = m_pc + s.im;
        if (s.r) begin
            m_pc = RST_PC; m_st = 0; m_cnt = '0;
        end else if (m_st == 0) begin
            if (s.hr)              m_st = 1;
            else if (s.st)         m_st = 0;
            else if (s.ps) begin
                if (tgt[1:0] != 2'b00) m_st = 2;
                else begin
                    m_pc  = tgt;
                    m_cnt = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
                end
            end else               m_pc = m_pc + 32'd4;
        end else if (m_st == 1) begin
            if (s.rs) m_st = 0;
        end
        e.pc = m_pc; e.halted = (m_st == 1); e.trap = (m_st == 2); e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(inout stim_t v[$], input int n);
        for (int i = 0; i < n; i++) v.push_back(mk(0, 0, 0, 0, 0, 32'h0));
    endtask

    task automatic test_reset();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        idle(v, 3);
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_seq[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        idle(v, 4);                                   // pc = 0x10
        v.push_back(mk(0, 1, 0, 0, 0, 32'hFFFF_FFF8)); // backward to 0x08
        v.push_back(mk(0, 1, 0, 0, 0, 32'h0000_0020)); // forward to 0x28
        v.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_stall();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        idle(v, 8);                                   // pc = 0x20
        v.push_back(mk(0, 1, 1, 0, 0, 32'h100));
        v.push_back(mk(0, 1, 1, 0, 0, 32'h100));
        v.push_back(mk(0, 0, 0, 0, 0, 32'h100));      // pc = 0x24
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_halt();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        idle(v, 12);                                  // pc = 0x30
        v.push_back(mk(0, 1, 0, 1, 0, 32'h8));
        for (int i = 0; i < 4; i++) v.push_back(mk(0, 1, 1, 1, 0, 32'h8));
        v.push_back(mk(0, 0, 0, 0, 1, 32'h0));        // resume: pc still 0x30
        v.push_back(mk(0, 0, 0, 0, 0, 32'h0));        // 0x34
        v.push_back(mk(0, 0, 0, 1, 0, 32'h0));        // halt again at 0x34
        v.push_back(mk(0, 0, 0, 1, 1, 32'h0));        // resume wins over halt_req
        v.push_back(mk(0, 0, 0, 0, 0, 32'h0));        // 0x38
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_trap();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        idle(v, 16);                                  // pc = 0x40
        v.push_back(mk(0, 1, 0, 0, 0, 32'h6));        // target 0x46 misaligned
        v.push_back(mk(0, 0, 0, 0, 1, 32'h0));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h0));
        v.push_back(mk(0, 1, 0, 0, 0, 32'h4));
        v.push_back(mk(0, 0, 1, 1, 1, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));        // only reset clears trap
        v.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trap[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_wrap_sat();
        stim_t v[$];
        obs_t  e, o;
        v.push_back(mk(1, 0, 0, 0, 0, 32'h0));
        v.push_back(mk(0, 1, 0, 0, 0, 32'hFFFF_FFFC)); // pc 0 -> 0xFFFF_FFFC
        v.push_back(mk(0, 0, 0, 0, 0, 32'h0));         // wraps to 0
        for (int i = 0; i < 5; i++) v.push_back(mk(0, 1, 0, 0, 0, 32'h4));
        v.push_back(mk(0, 1, 0, 0, 0, 32'h8));          // pc + imm wraps negative below? no: stays aligned
        v.push_back(mk(0, 1, 1, 1, 0, 32'h4));          // halt_req + stall pending
        v.push_back(mk(1, 1, 1, 1, 0, 32'h4));          // reset wins while halted with inputs high
        foreach (v[i]) begin
            step(v[i]);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap_sat[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t  e, o;
        logic [XLEN-1:0] im;
        step(mk(1, 0, 0, 0, 0, 32'h0));
        void'(sb.pop_front());
        for (int i = 0; i < 300; i++) begin
            im = {$urandom(), 2'b00};
            im = {im[XLEN-1:2], 2'b00};
            if ($urandom_range(7) == 0) im[1:0] = 2'($urandom_range(3));
            s = mk($urandom_range(24) == 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
                   $urandom_range(9) == 0, $urandom_range(3) == 0, im);
            step(s);
            e = sb.pop_front(); o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b[%0d] got pc=%h h=%b t=%b cnt=%0d want pc=%h h=%b t=%b cnt=%0d",
                         i, o.pc, o.halted, o.trap, o.cnt, e.pc, e.halted, e.trap, e.cnt);
            end
            checks++;
            if (pc_plus4 !== m_pc + 32'd4 || branch_target !== m_pc + im) begin
                errors++;
                $display("FAIL adders[%0d] got p4=%h bt=%h want p4=%h bt=%h",
                         i, pc_plus4, branch_target, m_pc + 32'd4, m_pc + im);
            end
        end
    endtask

    initial begin
        reset = 1'b1; pc_src = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0; imm = '0;
        m_pc = RST_PC; m_st = 0; m_cnt = '0;
        @(negedge clk);
        test_reset();
        test_branch();
        test_stall();
        test_halt();
        test_trap();
        test_wrap_sat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter register and next-PC sequencer for the single-cycle RISC-V core.
- Sits at the receiving end of the branch-decision path: it consumes the pc_src bit (zero AND branch) and applies it to the PC.
- Adds stall, halt/resume and misaligned-target trap control.
- Keeps a saturating count of taken branches for debug.

Parameters:
XLEN, 32, datapath and PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of taken-branch counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_src  input  1  branch taken decision (zero AND branch) for the instruction at current pc
imm  input  XLEN  sign-extended branch offset, bytes, already shifted
stall  input  1  hold PC this cycle
halt_req  input  1  request transition to HALT
resume  input  1  leave HALT
pc  output  XLEN  current instruction address (registered)
pc_plus4  output  XLEN  pc + 4, combinational, modulo 2^XLEN
branch_target  output  XLEN  pc + imm, combinational, modulo 2^XLEN
halted  output  1  high while in HALT (registered-state decode)
trap  output  1  misaligned branch target trap, sticky
taken_count  output  CNT_W  saturating count of applied taken branches

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset has priority over every other input.
  - Reset values: pc=RESET_PC, state=RUN, halted=0, trap=0, taken_count=0.
- States:
  - RUN: normal sequencing.
  - HALT: pc frozen, halted=1.
  - TRAP: pc frozen, trap=1.
- RUN, per edge, first matching rule wins:
  1. halt_req=1 -> state=HALT next cycle; pc unchanged; pc_src ignored; counter unchanged.
  2. stall=1 -> pc unchanged; pc_src ignored; counter unchanged.
  3. pc_src=1 and branch_target[1:0]!=2'b00 -> state=TRAP; pc unchanged, holding the faulting branch address; counter unchanged.
  4. pc_src=1, target aligned -> pc<=branch_target; taken_count<=taken_count+1, saturating at all-ones.
  5. otherwise -> pc<=pc_plus4.
- HALT:
  - pc held; all inputs except reset and resume are ignored.
  - resume=1 -> RUN on the next edge; pc is not advanced on that edge.
  - First advance happens on the following edge, per the RUN rules.
  - halt_req and resume both high in HALT -> resume wins.
- TRAP:
  - pc held, trap=1; only reset exits.
  - halt_req, resume, stall and pc_src are all ignored.
- Arithmetic:
  - Both adders are XLEN-bit and wrap silently, with no overflow flag.
  - pc=32'hFFFF_FFFC with no branch -> pc becomes 32'h0000_0000.
  - Negative imm (two's complement) yields a backward branch.
- Latency:
  - A decision at edge N is visible on pc after edge N.
  - pc_plus4 and branch_target follow pc with zero cycle delay.
- Alignment:
  - Only bits [1:0] are checked; there is no compressed-ISA support.
  - RESET_PC must be 4-byte aligned; unaligned values are unsupported.
- Reset mid-operation: reset asserted in any state, including while stall/halt_req are high, returns to RUN at RESET_PC on that edge.

Test Plan:
- Reset then 3 idle cycles (pc_src=0, stall=0) -> pc sequence 0x0, 0x4, 0x8, 0xC; halted=0, trap=0, taken_count=0.
- At pc=0x10, pc_src=1, imm=0xFFFF_FFF8 -> next pc=0x08, taken_count=1; repeat with imm=0x20 at pc=0x08 -> pc=0x28, taken_count=2.
- At pc=0x20, stall=1 with pc_src=1, imm=0x100 for 2 cycles -> pc stays 0x20, taken_count unchanged; stall drops with pc_src=0 -> pc=0x24.
- At pc=0x30, halt_req=1 -> halted=1, pc=0x30 for 4 cycles despite pc_src=1; resume=1 -> halted=0, pc still 0x30 for that edge, then 0x34.
- At pc=0x40, pc_src=1, imm=0x6 -> trap=1, pc held 0x40; resume/halt_req have no effect; reset -> trap=0, pc=RESET_PC.
- Wrap and saturation: force pc to 0xFFFF_FFFC, idle -> pc=0x0; with CNT_W=2, apply 5 aligned taken branches -> taken_count=3 and stays 3.
